// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: 2-flop sync, per-pin debounce, edge detect,
// pending latch and level IRQ, configured over an APB slave.
module gpio_in_cond #(
    parameter int NPIN  = 16,
    parameter int CNT_W = 8
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  logic [31:0]     PADDR,
    input  logic [31:0]     PWDATA,
    output logic [31:0]     PRDATA,
    input  logic [NPIN-1:0] GPIO_IN,
    output logic [NPIN-1:0] GPIO_DB,
    output logic            IRQ
);

    localparam logic [1:0] A_IRQ_EN = 2'd0;
    localparam logic [1:0] A_EDGE   = 2'd1;
    localparam logic [1:0] A_THR    = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [NPIN-1:0]  irq_en;
    logic [NPIN-1:0]  rise_en;
    logic [NPIN-1:0]  fall_en;
    logic [CNT_W-1:0] db_thr;
    logic [NPIN-1:0]  pending;
    logic [NPIN-1:0]  sync1;
    logic [NPIN-1:0]  sync2;
    logic [CNT_W-1:0] cnt [NPIN];

    logic [NPIN-1:0] db_hit;
    logic [NPIN-1:0] set_pend;
    logic [NPIN-1:0] clr_pend;
    logic [1:0]      addr;
    logic            wr_en;
    logic            unused_bits;

    assign addr        = PADDR[3:2];
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA};

    // >= so a threshold lowered below a running count fires next cycle
    always_comb begin
        db_hit = '0;
        for (int i = 0; i < NPIN; i++) begin
            db_hit[i] = (sync2[i] != GPIO_DB[i]) && (cnt[i] >= db_thr);
        end
    end

    assign set_pend = (db_hit & sync2 & rise_en)
                    | (db_hit & ~sync2 & fall_en);
    assign clr_pend = (wr_en && addr == A_STATUS)
                    ? PWDATA[NPIN-1:0] : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1   <= '0;
            sync2   <= '0;
            GPIO_DB <= '0;
            for (int i = 0; i < NPIN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= GPIO_IN;
            sync2 <= sync1;
            for (int i = 0; i < NPIN; i++) begin
                if (sync2[i] == GPIO_DB[i]) begin
                    cnt[i] <= '0;
                end else if (db_hit[i]) begin
                    GPIO_DB[i] <= sync2[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_en  <= '0;
            rise_en <= '0;
            fall_en <= '0;
            db_thr  <= '0;
        end else if (wr_en) begin
            unique case (addr)
                A_IRQ_EN: irq_en <= PWDATA[NPIN-1:0];
                A_EDGE: begin
                    rise_en <= PWDATA[NPIN-1:0];
                    fall_en <= PWDATA[16 +: NPIN];
                end
                A_THR:    db_thr <= PWDATA[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // set beats a same-edge clear
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_pend) | set_pend;
        end
    end

    assign IRQ = |(pending & irq_en);

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            unique case (addr)
                A_IRQ_EN: PRDATA = 32'(irq_en);
                A_EDGE:   PRDATA = {16'(fall_en), 16'(rise_en)};
                A_THR:    PRDATA = 32'(db_thr);
                default:  PRDATA = {16'(GPIO_DB), 16'(pending)};
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond: reset, debounce latency, glitch,
// falling/mask, set/clear collision, threshold change, reset mid-count.
module tb_gpio_in_cond;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic [15:0] GPIO_IN;
    logic [15:0] GPIO_DB;
    logic        IRQ;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;

    gpio_in_cond #(.NPIN(16), .CNT_W(8)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .GPIO_IN (GPIO_IN),
        .GPIO_DB (GPIO_DB),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_wr(input logic [1:0] a, input logic [31:0] d);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = {28'h0, a, 2'b00};
        PWDATA  = d;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_rd(input logic [1:0] a, output logic [31:0] d);
        PSEL   = 1'b1;
        PWRITE = 1'b0;
        PADDR  = {28'h0, a, 2'b00};
        #1;
        d = PRDATA;
        PSEL = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        GPIO_IN = 16'hFFFF;

        repeat (3) tick();
        chk("rst_db", 32'(GPIO_DB), 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        apb_rd(2'd3, rd);
        chk("rst_status", rd, 32'h0);
        #1;
        chk("idle_prdata", PRDATA, 32'h0);

        PRESET = 1'b0;
        tick();
        tick();
        chk("rel_db_e1", 32'(GPIO_DB), 32'h0);
        tick();
        chk("rel_db_e2", 32'(GPIO_DB), 32'hFFFF);

        GPIO_IN = 16'h0000;
        repeat (4) tick();
        chk("all_low", 32'(GPIO_DB), 32'h0);

        apb_wr(2'd2, 32'd3);
        apb_wr(2'd1, 32'h1);
        apb_wr(2'd0, 32'h1);
        GPIO_IN = 16'h0001;
        repeat (5) tick();
        chk("lat_e4_db", 32'(GPIO_DB), 32'h0);
        chk("lat_e4_irq", 32'(IRQ), 32'h0);
        tick();
        chk("lat_e5_db", 32'(GPIO_DB), 32'h1);
        chk("lat_e5_irq", 32'(IRQ), 32'h1);
        apb_rd(2'd3, rd);
        chk("lat_status", rd, 32'h0001_0001);
        apb_wr(2'd3, 32'h1);
        chk("w1c_irq", 32'(IRQ), 32'h0);
        apb_rd(2'd3, rd);
        chk("w1c_status", rd, 32'h0001_0000);

        apb_wr(2'd1, 32'h3);
        apb_wr(2'd0, 32'h3);
        GPIO_IN = 16'h0003;
        repeat (3) tick();
        GPIO_IN = 16'h0001;
        repeat (10) tick();
        chk("glitch_db", 32'(GPIO_DB), 32'h1);
        chk("glitch_irq", 32'(IRQ), 32'h0);
        apb_rd(2'd3, rd);
        chk("glitch_status", rd, 32'h0001_0000);

        apb_wr(2'd0, 32'h0);
        apb_wr(2'd1, 32'h0004_0000);
        GPIO_IN = 16'h0005;
        repeat (8) tick();
        apb_rd(2'd3, rd);
        chk("fall_pre", rd, 32'h0005_0000);
        GPIO_IN = 16'h0001;
        repeat (8) tick();
        apb_rd(2'd3, rd);
        chk("fall_pend", rd, 32'h0001_0004);
        chk("fall_masked", 32'(IRQ), 32'h0);
        apb_wr(2'd0, 32'h0004);
        chk("unmask_irq", 32'(IRQ), 32'h1);
        apb_rd(2'd0, rd);
        chk("irq_en_rd", rd, 32'h0004);
        apb_wr(2'd3, 32'h4);
        chk("fall_clr_irq", 32'(IRQ), 32'h0);

        apb_wr(2'd2, 32'hFFFF_FFFF);
        apb_rd(2'd2, rd);
        chk("thr_rd", rd, 32'h0000_00FF);
        apb_rd(2'd1, rd);
        chk("edge_rd", rd, 32'h0004_0000);

        apb_wr(2'd2, 32'd0);
        apb_wr(2'd1, 32'h8);
        apb_wr(2'd0, 32'h8);
        GPIO_IN = 16'h0009;
        tick();
        apb_wr(2'd3, 32'h8);
        apb_rd(2'd3, rd);
        chk("coll_status", rd, 32'h0009_0008);
        chk("coll_irq", 32'(IRQ), 32'h1);
        apb_wr(2'd3, 32'h8);
        apb_rd(2'd3, rd);
        chk("coll_clr", rd, 32'h0009_0000);
        chk("coll_clr_irq", 32'(IRQ), 32'h0);

        apb_wr(2'd2, 32'd10);
        apb_wr(2'd1, 32'h0);
        GPIO_IN = 16'h0029;
        repeat (7) tick();
        apb_wr(2'd2, 32'd2);
        chk("thr_low_e8", 32'(GPIO_DB), 32'h0009);
        tick();
        chk("thr_low_e9", 32'(GPIO_DB), 32'h0029);

        apb_wr(2'd2, 32'd10);
        GPIO_IN = 16'h0039;
        repeat (5) tick();
        chk("mid_pre", 32'(GPIO_DB), 32'h0029);
        PRESET  = 1'b1;
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 32'h8;
        PWDATA  = 32'd10;
        tick();
        chk("mid_rst_db", 32'(GPIO_DB), 32'h0);
        PRESET  = 1'b0;
        PENABLE = 1'b1;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        apb_rd(2'd2, rd);
        chk("mid_thr", rd, 32'd10);
        repeat (11) tick();
        chk("mid_e11", 32'(GPIO_DB), 32'h0);
        tick();
        chk("mid_e12", 32'(GPIO_DB), 32'h0039);
        apb_rd(2'd3, rd);
        chk("mid_status", rd, 32'h0039_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
